// File: rtl/fifo1_arb_pkg.sv
// rtl/fifo1_arb_pkg.sv - shared sizing and types for the one-entry arbitrated FIFO
package fifo1_arb_pkg;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int SRC_W = 2;

  typedef logic [SRC_W-1:0] src_t;

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational round-robin pick over four requesters
module rr_pick4
  import fifo1_arb_pkg::*;
(
  input  logic [3:0] req,
  input  src_t       ptr,
  output logic [3:0] grant,
  output src_t       grant_idx
);

  src_t idx;
  logic found;

  // Scan ptr, ptr+1, ... with natural 2-bit wrap; first requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    found     = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + src_t'(k);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/fifo1_arbiter.sv
// rtl/fifo1_arbiter.sv - one-entry FIFO with round-robin arbitration of four enqueuers
module fifo1_arbiter
  import fifo1_arb_pkg::*;
#(
  parameter int NREQ  = fifo1_arb_pkg::NREQ,
  parameter int WIDTH = fifo1_arb_pkg::WIDTH
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [NREQ-1:0]       in_enq__REQ,
  input  logic [NREQ-1:0]       in_enq__ENA,
  input  logic [NREQ*WIDTH-1:0] in_enq_v,
  output logic [NREQ-1:0]       in_enq__RDY,
  input  logic                  out_deq__ENA,
  output logic                  out_deq__RDY,
  output logic [WIDTH-1:0]      out_first,
  output src_t                  out_first_src,
  output logic                  out_first__RDY
);

  logic [WIDTH-1:0] element;
  src_t             src;
  src_t             ptr;
  logic             full;

  logic [3:0]       grant;
  src_t             grant_idx;
  logic             enq_fire;
  logic [WIDTH-1:0] slot [NREQ];

  rr_pick4 u_pick (
    .req       (in_enq__REQ),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  for (genvar i = 0; i < NREQ; i++) begin : g_slot
    assign slot[i] = in_enq_v[i*WIDTH +: WIDTH];
  end

  // Ready is a pure function of state and REQ, never of the strobes.
  assign in_enq__RDY = full ? '0 : grant;
  // Grant is one-hot, so at most one port can fire per cycle.
  assign enq_fire    = |(in_enq__ENA & in_enq__RDY);

  assign out_deq__RDY   = full;
  assign out_first__RDY = full;
  assign out_first      = element;
  assign out_first_src  = src;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      full    <= 1'b0;
      element <= '0;
      src     <= '0;
      ptr     <= '0;
    end else if (enq_fire) begin
      full    <= 1'b1;
      element <= slot[grant_idx];
      src     <= grant_idx;
      ptr     <= grant_idx + 2'd1;
    end else if (out_deq__ENA && full) begin
      full    <= 1'b0;
    end
  end

endmodule

// File: doc/fifo1_arbiter.md
FIFO1_ARBITER -- requirements
Module: fifo1_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning number of enqueue requesters (fixed at 4 in this revision).
REQ-002 SHALL have parameter WIDTH, default 32, meaning data word width.
REQ-003 CLK  input  1  clock; all state updates on posedge CLK.
REQ-004 nRST  input  1  reset; synchronous, active-low.
REQ-005 in_enq__REQ  input  NREQ  per-requester intent to enqueue; level; independent of RDY.
REQ-006 in_enq__ENA  input  NREQ  per-requester enqueue strobe.
REQ-007 in_enq_v  input  NREQ*WIDTH  per-requester data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 in_enq__RDY  output  NREQ  per-requester grant/ready.
REQ-009 out_deq__ENA  input  1  consumer dequeue strobe.
REQ-010 out_deq__RDY  output  1  entry available for dequeue.
REQ-011 out_first  output  WIDTH  held data word.
REQ-012 out_first_src  output  2  index of requester that wrote the held word.
REQ-013 out_first__RDY  output  1  out_first/out_first_src valid.

Function
REQ-014 SHALL hold one entry: element[WIDTH], src[2], full flag, plus 2-bit round-robin pointer ptr.
REQ-015 Grant: grant = one-hot of first index j in order ptr, ptr+1, ..., ptr+3 (mod 4) with in_enq__REQ[j]=1; all-zero if no REQ.
REQ-016 in_enq__RDY[i] SHALL equal !full && grant[i]; it SHALL NOT depend combinationally on in_enq__ENA or out_deq__ENA.
REQ-017 Accepted enqueue: in_enq__ENA[i] && in_enq__RDY[i]; at most one per cycle.
REQ-018 On accepted enqueue from i: element <= in_enq_v slice i, src <= i, full <= 1, ptr <= (i+1) mod 4, next cycle.
REQ-019 ENA on a port whose RDY is 0 SHALL be ignored: no state change, no data capture.
REQ-020 out_deq__RDY = out_first__RDY = full; out_first = element; out_first_src = src.
REQ-021 Accepted dequeue (out_deq__ENA && full): full <= 0 next cycle; element/src retain value; ptr unchanged.
REQ-022 Enqueue and dequeue are mutually exclusive by construction (RDY needs !full, deq needs full); no bypass; enqueue-to-first latency 1 cycle, min 2 cycles between accepted enqueues.
REQ-023 ptr SHALL change only on accepted enqueue; REQ without ENA leaves ptr unchanged (grant stays on that requester).
REQ-024 Fairness: with all 4 REQ/ENA held high and consumer always dequeuing, grant order SHALL be 0,1,2,3,0,...

Reset
REQ-025 While nRST=0 at posedge: full <= 0, element <= 0, src <= 0, ptr <= 0; all inputs ignored.
REQ-026 After reset: out_deq__RDY=0, out_first__RDY=0, out_first=0, out_first_src=0, in_enq__RDY=grant (empty).
REQ-027 Reset asserted while full SHALL discard the entry; no dequeue event is required.

Structure
REQ-028 NREQ, WIDTH, source-index width (2) SHALL live in shared package fifo1_arb_pkg.
REQ-029 Round-robin pick SHALL be sub-module rr_pick4 (inputs req[4], ptr[2]; output grant[4], grant_idx[2]); purely combinational.
REQ-030 Storage/ptr update SHALL be a single always @(posedge CLK) block with nRST branch first.

Verification
REQ-031 Reset, then REQ=0001, ENA=0001, v0=0xDEADBEEF -> next cycle out_first__RDY=1, out_first=0xDEADBEEF, src=0, ptr=1, all in_enq__RDY=0.
REQ-032 Full, out_deq__ENA=1 one cycle -> full=0 next cycle, out_first still 0xDEADBEEF, out_deq__RDY=0.
REQ-033 All REQ/ENA=1111, v_i=0x100+i, deq every cycle full -> accepted src sequence 0,1,2,3,0 with data 0x100..0x103,0x100.
REQ-034 ptr=2, REQ=0011 -> grant=0001 (wrap past 2,3); ENA=0010 only -> ignored, no capture, ptr stays 2.
REQ-035 Full, ENA=1111 and REQ=1111 -> all RDY=0, element/src unchanged.
REQ-036 Full with src=3, nRST=0 one cycle -> full=0, out_first=0, src=0, ptr=0.
